// File: rtl/credit_payout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : credit_payout_ctrl
// Description : Slot-machine credit counter and game FSM. It counts coins,
//               debits a credit on start, evaluates the reels and counts the
//               award in, one credit per TICK.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_payout_ctrl #(
    parameter int MAX_CREDIT = 99,
    parameter int PAY_TRIPLE = 10,
    parameter int PAY_PAIR   = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       C_IN,
    input  logic       GAME_START,
    input  logic       REEL_DONE,
    input  logic [3:0] REEL1,
    input  logic [3:0] REEL2,
    input  logic [3:0] REEL3,
    input  logic       TICK,
    output logic [6:0] CREDIT,
    output logic       SPIN_EN,
    output logic       PAY_BUSY,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        SPIN   = 3'd2,
        EVAL   = 3'd3,
        PAYOUT = 3'd4
    } state_t;

    localparam logic [7:0] c_max_credit = 8'(MAX_CREDIT);
    localparam logic [4:0] c_pay_triple = 5'(PAY_TRIPLE);
    localparam logic [4:0] c_pay_pair   = 5'(PAY_PAIR);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_credit;
    logic [6:0] w_credit_nxt;
    logic [7:0] w_credit_sum;
    logic [4:0] r_remaining;
    logic [4:0] w_remaining_nxt;
    logic [4:0] w_award;
    logic       r_cin_prev;
    logic       r_cin_armed;
    logic       r_start_prev;
    logic       w_coin;
    logic       w_start;
    logic       w_has_credit;
    logic       w_debit;
    logic       w_tick_pay;

    // A coin only counts once C_IN has been seen low after reset, so a button
    // held through reset release does not produce a phantom coin.
    assign w_coin       = C_IN & ~r_cin_prev & r_cin_armed;
    assign w_start      = GAME_START & ~r_start_prev;
    assign w_has_credit = (r_credit != 7'd0);

    always_comb begin
        w_award = 5'd0;
        if ((REEL1 == REEL2) && (REEL2 == REEL3)) begin
            w_award = c_pay_triple;
        end else if ((REEL1 == REEL2) || (REEL2 == REEL3) || (REEL1 == REEL3)) begin
            w_award = c_pay_pair;
        end
    end

    always_comb begin
        w_state_nxt     = IDLE;
        w_remaining_nxt = r_remaining;
        w_debit         = 1'b0;
        w_tick_pay      = 1'b0;
        case (r_state)
            IDLE:   w_state_nxt = w_has_credit ? READY : IDLE;
            READY: begin
                w_state_nxt = READY;
                if (w_start && w_has_credit) begin
                    w_debit     = 1'b1;
                    w_state_nxt = SPIN;
                end
            end
            SPIN:   w_state_nxt = REEL_DONE ? EVAL : SPIN;
            EVAL: begin
                w_remaining_nxt = w_award;
                if (w_award != 5'd0) begin
                    w_state_nxt = PAYOUT;
                end else begin
                    w_state_nxt = w_has_credit ? READY : IDLE;
                end
            end
            PAYOUT: begin
                if (r_remaining == 5'd0) begin
                    w_state_nxt = w_has_credit ? READY : IDLE;
                end else begin
                    w_state_nxt = PAYOUT;
                    if (TICK) begin
                        w_tick_pay      = 1'b1;
                        w_remaining_nxt = r_remaining - 5'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Debit only happens with credit >= 1, so the 8-bit sum never wraps low.
    assign w_credit_sum = {1'b0, r_credit} + {7'd0, w_coin} + {7'd0, w_tick_pay}
                        - {7'd0, w_debit};
    assign w_credit_nxt = (w_credit_sum > c_max_credit) ? c_max_credit[6:0]
                                                        : w_credit_sum[6:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_credit     <= 7'd0;
            r_remaining  <= 5'd0;
            r_cin_prev   <= 1'b0;
            r_cin_armed  <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_credit     <= w_credit_nxt;
            r_remaining  <= w_remaining_nxt;
            r_cin_prev   <= C_IN;
            r_start_prev <= GAME_START;
            if (!C_IN) begin
                r_cin_armed <= 1'b1;
            end
        end
    end

    assign CREDIT   = r_credit;
    assign STATE    = r_state;
    assign SPIN_EN  = (r_state == SPIN);
    assign PAY_BUSY = (r_state == PAYOUT);

endmodule
`default_nettype wire

// File: tb/tb_credit_payout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_payout_ctrl
// Description : Scenario bench for credit_payout_ctrl against a credit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_payout_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       C_IN = 1'b0;
    logic       GAME_START = 1'b0;
    logic       REEL_DONE = 1'b0;
    logic [3:0] REEL1 = 4'd0;
    logic [3:0] REEL2 = 4'd0;
    logic [3:0] REEL3 = 4'd0;
    logic       TICK = 1'b0;
    logic [6:0] CREDIT;
    logic       SPIN_EN;
    logic       PAY_BUSY;
    logic [2:0] STATE;

    int total = 0;
    int bad = 0;
    int exp_credit = 0;

    credit_payout_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .C_IN       (C_IN),
        .GAME_START (GAME_START),
        .REEL_DONE  (REEL_DONE),
        .REEL1      (REEL1),
        .REEL2      (REEL2),
        .REEL3      (REEL3),
        .TICK       (TICK),
        .CREDIT     (CREDIT),
        .SPIN_EN    (SPIN_EN),
        .PAY_BUSY   (PAY_BUSY),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int award(input int a, input int b, input int c);
        if (a == b && b == c) return 10;
        if (a == b || b == c || a == c) return 5;
        return 0;
    endfunction

    function automatic int sat(input int x);
        return (x > 99) ? 99 : x;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic coin_pulse();
        C_IN = 1'b1;
        cycle();
        C_IN = 1'b0;
        cycle();
        exp_credit = sat(exp_credit + 1);
    endtask

    task automatic do_reset();
        RST = 1'b1; C_IN = 1'b0; GAME_START = 1'b0; REEL_DONE = 1'b0; TICK = 1'b0;
        cycle();
        RST = 1'b0;
        cycle();
        exp_credit = 0;
    endtask

    task automatic check_credit_state(input string name, input int est);
        total++;
        if (CREDIT !== 7'(exp_credit) || STATE !== 3'(est)) begin
            bad++;
            $display("FAIL %s: credit=%0d state=%0d, required credit=%0d state=%0d",
                     name, CREDIT, STATE, exp_credit, est);
        end
    endtask

    // One game round from READY; coin_tick injects a coin with that TICK,
    // abort_tick asserts RST during that TICK instead of finishing.
    task automatic do_spin(input int a, input int b, input int c,
                           input int coin_tick, input int abort_tick);
        int aw;
        aw = award(a, b, c);
        GAME_START = 1'b1;
        cycle();
        GAME_START = 1'b0;
        exp_credit = exp_credit - 1;
        total++;
        if (STATE !== 3'd2 || SPIN_EN !== 1'b1 || CREDIT !== 7'(exp_credit)) begin
            bad++;
            $display("FAIL spin_entry: state=%0d spin_en=%0b credit=%0d, required 2/1/%0d",
                     STATE, SPIN_EN, CREDIT, exp_credit);
        end
        repeat ($urandom_range(0, 3)) begin
            REEL1 = 4'($urandom_range(0, 9));
            REEL2 = 4'($urandom_range(0, 9));
            cycle();
        end
        REEL1 = 4'(a); REEL2 = 4'(b); REEL3 = 4'(c); REEL_DONE = 1'b1;
        cycle();
        REEL_DONE = 1'b0;
        total++;
        if (STATE !== 3'd3 || SPIN_EN !== 1'b0) begin
            bad++;
            $display("FAIL eval_entry: state=%0d spin_en=%0b, required 3/0", STATE, SPIN_EN);
        end
        cycle();
        REEL1 = 4'($urandom_range(0, 9)); REEL2 = 4'($urandom_range(0, 9));
        REEL3 = 4'($urandom_range(0, 9));
        if (aw > 0) begin
            total++;
            if (STATE !== 3'd4 || PAY_BUSY !== 1'b1) begin
                bad++;
                $display("FAIL payout_entry: state=%0d busy=%0b, required 4/1", STATE, PAY_BUSY);
            end
            for (int t = 0; t < aw; t++) begin
                repeat ($urandom_range(0, 2)) cycle();
                TICK = 1'b1;
                if (t == abort_tick) begin
                    #2;
                    RST = 1'b1;
                    #1;
                    total++;
                    if (STATE !== 3'd0 || CREDIT !== 7'd0 || SPIN_EN !== 1'b0 || PAY_BUSY !== 1'b0) begin
                        bad++;
                        $display("FAIL async_reset: state=%0d credit=%0d spin=%0b busy=%0b, required all 0",
                                 STATE, CREDIT, SPIN_EN, PAY_BUSY);
                    end
                    TICK = 1'b0;
                    cycle();
                    RST = 1'b0;
                    exp_credit = 0;
                    return;
                end
                if (t == coin_tick) C_IN = 1'b1;
                cycle();
                TICK = 1'b0;
                exp_credit = sat(exp_credit + 1 + ((t == coin_tick) ? 1 : 0));
                C_IN = 1'b0;
            end
            total++;
            if (PAY_BUSY !== 1'b1 || CREDIT !== 7'(exp_credit)) begin
                bad++;
                $display("FAIL payout_last: busy=%0b credit=%0d, required 1/%0d",
                         PAY_BUSY, CREDIT, exp_credit);
            end
            cycle();
        end
        total++;
        if (STATE !== ((exp_credit >= 1) ? 3'd1 : 3'd0) || PAY_BUSY !== 1'b0 ||
            CREDIT !== 7'(exp_credit)) begin
            bad++;
            $display("FAIL spin_exit reels=%0d%0d%0d: state=%0d busy=%0b credit=%0d, required credit=%0d",
                     a, b, c, STATE, PAY_BUSY, CREDIT, exp_credit);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #3;
        total++;
        if (STATE !== 3'd0 || CREDIT !== 7'd0 || SPIN_EN !== 1'b0 || PAY_BUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: state=%0d credit=%0d spin=%0b busy=%0b, required all 0",
                     STATE, CREDIT, SPIN_EN, PAY_BUSY);
        end
        cycle();
        RST = 1'b0;
        cycle();
        exp_credit = 0;
    endtask

    task automatic test_coins();
        repeat (3) coin_pulse();
        check_credit_state("three_coins", 1);
        C_IN = 1'b1;
        repeat (50) cycle();
        C_IN = 1'b0;
        cycle();
        exp_credit = 4;
        check_credit_state("held_coin", 1);
        repeat ($urandom_range(1, 5)) coin_pulse();
        check_credit_state("random_coins", 1);
    endtask

    task automatic test_awards();
        do_reset();
        coin_pulse();
        do_spin(7, 7, 7, -1, -1);
        check_credit_state("triple", 1);
        do_spin(3, 5, 3, -1, -1);
        check_credit_state("pair", 1);
        do_spin(1, 2, 3, -1, -1);
        check_credit_state("no_win", 1);
        do_reset();
        coin_pulse();
        do_spin(1, 2, 3, -1, -1);
        check_credit_state("no_win_idle", 0);
    endtask

    task automatic test_same_cycle();
        do_reset();
        GAME_START = 1'b1;
        cycle();
        GAME_START = 1'b0;
        cycle();
        check_credit_state("start_in_idle", 0);
        coin_pulse();
        coin_pulse();
        C_IN = 1'b1; GAME_START = 1'b1;
        cycle();
        C_IN = 1'b0; GAME_START = 1'b0;
        cycle();
        check_credit_state("coin_and_start", 2);
        GAME_START = 1'b1;
        cycle();
        GAME_START = 1'b0;
        cycle();
        check_credit_state("start_in_spin", 2);
        REEL1 = 4'd1; REEL2 = 4'd2; REEL3 = 4'd3; REEL_DONE = 1'b1;
        cycle();
        REEL_DONE = 1'b0;
        cycle();
        check_credit_state("same_cycle_exit", 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int a, b, c, ct;
            repeat ($urandom_range(0, 3)) coin_pulse();
            if (exp_credit == 0) coin_pulse();
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            ct = (award(a, b, c) > 0) ? $urandom_range(0, award(a, b, c)) : -1;
            do_spin(a, b, c, ct, -1);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (96) coin_pulse();
        check_credit_state("ninety_six", 1);
        do_spin(7, 7, 7, 1, -1);
        check_credit_state("saturated_payout", 1);
        coin_pulse();
        check_credit_state("coin_at_ceiling", 1);
    endtask

    task automatic test_reset_mid_payout();
        do_reset();
        coin_pulse();
        do_spin(7, 7, 7, -1, 3);
        repeat (5) begin
            TICK = 1'b1;
            cycle();
            TICK = 1'b0;
            cycle();
        end
        check_credit_state("no_residual_award", 0);
        coin_pulse();
        check_credit_state("coin_after_abort", 1);
    endtask

    task automatic test_reset_cin_high();
        RST = 1'b1; C_IN = 1'b1;
        cycle();
        RST = 1'b0;
        repeat (5) cycle();
        exp_credit = 0;
        check_credit_state("cin_high_release", 0);
        C_IN = 1'b0;
        cycle();
        C_IN = 1'b1;
        cycle();
        C_IN = 1'b0;
        cycle();
        exp_credit = 1;
        check_credit_state("cin_rearmed", 1);
    endtask

    initial begin
        test_reset();
        test_coins();
        test_awards();
        test_same_cycle();
        test_random();
        test_saturation();
        test_reset_mid_payout();
        test_reset_cin_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
